// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings used by the decoder, the ALU and the arbiter,
// plus the arbiter's round-robin pointer type.
package alu_pkg;

    localparam int CTRL_WIDTH = 4;

    localparam logic [CTRL_WIDTH-1:0] ALU_ADD  = 4'b0000;
    localparam logic [CTRL_WIDTH-1:0] ALU_SLL  = 4'b0001;
    localparam logic [CTRL_WIDTH-1:0] ALU_SLT  = 4'b0010;
    localparam logic [CTRL_WIDTH-1:0] ALU_SLTU = 4'b0011;
    localparam logic [CTRL_WIDTH-1:0] ALU_XOR  = 4'b0100;
    localparam logic [CTRL_WIDTH-1:0] ALU_SRL  = 4'b0101;
    localparam logic [CTRL_WIDTH-1:0] ALU_SRA  = 4'b1101;
    localparam logic [CTRL_WIDTH-1:0] ALU_OR   = 4'b0110;
    localparam logic [CTRL_WIDTH-1:0] ALU_AND  = 4'b0111;

    typedef enum logic {
        PRIO_REQ0 = 1'b0,
        PRIO_REQ1 = 1'b1
    } prio_t;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU shared across the pipeline; unknown ctrl encodings yield zero.
module ALU
    import alu_pkg::*;
#(
    parameter int REG_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic [REG_DATA_WIDTH-1:0] din_0,
    input  logic [REG_DATA_WIDTH-1:0] din_1,
    input  logic [CTRL_WIDTH-1:0]     ctrl,
    output logic [REG_DATA_WIDTH-1:0] result
);

    localparam int SHW = $clog2(REG_DATA_WIDTH);

    // Clock and reset are part of the ALU's port contract but the datapath is purely combinational.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ nreset;

    logic [SHW-1:0] shamt;
    assign shamt = din_1[SHW-1:0];

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD:  result = din_0 + din_1;
            ALU_SLL:  result = din_0 << shamt;
            ALU_SLT:  result = {{(REG_DATA_WIDTH-1){1'b0}}, $signed(din_0) < $signed(din_1)};
            ALU_SLTU: result = {{(REG_DATA_WIDTH-1){1'b0}}, din_0 < din_1};
            ALU_XOR:  result = din_0 ^ din_1;
            ALU_SRL:  result = din_0 >> shamt;
            ALU_SRA:  result = $unsigned($signed(din_0) >>> shamt);
            ALU_OR:   result = din_0 | din_1;
            ALU_AND:  result = din_0 & din_1;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arb_slot.sv
// One-entry registered response buffer: push captures a result, pop without push empties it,
// otherwise the stored result is held.
module alu_arb_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic [WIDTH-1:0] result
);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            valid  <= 1'b0;
            result <= '0;
        end else if (push) begin
            valid  <= 1'b1;
            result <= din;
        end else if (pop) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between execute (req 0) and AGU/branch-target (req 1).
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters.
module alu_arbiter #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int CTRL_WIDTH     = alu_pkg::CTRL_WIDTH
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [REG_DATA_WIDTH-1:0] req0_din_0,
    input  logic [REG_DATA_WIDTH-1:0] req0_din_1,
    input  logic [CTRL_WIDTH-1:0]     req0_ctrl,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [REG_DATA_WIDTH-1:0] req1_din_0,
    input  logic [REG_DATA_WIDTH-1:0] req1_din_1,
    input  logic [CTRL_WIDTH-1:0]     req1_ctrl,
    output logic                      rsp0_valid,
    input  logic                      rsp0_ready,
    output logic [REG_DATA_WIDTH-1:0] rsp0_result,
    output logic                      rsp1_valid,
    input  logic                      rsp1_ready,
`ifdef ALU_ARB_STATS_EN
    output logic [REG_DATA_WIDTH-1:0] rsp1_result,
    output logic [31:0]               stat_grant0,
    output logic [31:0]               stat_grant1
`else
    output logic [REG_DATA_WIDTH-1:0] rsp1_result
`endif
);

    import alu_pkg::*;

    prio_t prio, prio_next;
    logic  elig0, elig1;
    logic  grant0, grant1;
    logic  pop0, pop1;

    logic [REG_DATA_WIDTH-1:0] alu_din_0, alu_din_1, alu_result;
    logic [CTRL_WIDTH-1:0]     alu_ctrl;

    // A slot being drained this cycle can accept a new result on the same edge.
    assign pop0  = rsp0_valid && rsp0_ready;
    assign pop1  = rsp1_valid && rsp1_ready;
    assign elig0 = req0_valid && (!rsp0_valid || rsp0_ready);
    assign elig1 = req1_valid && (!rsp1_valid || rsp1_ready);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            prio <= PRIO_REQ0;
        end else begin
            prio <= prio_next;
        end
    end

    // Grants are masked by reset so no op is accepted while state is being cleared.
    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        prio_next = prio;
        if (nreset) begin
            grant0 = elig0 && (!elig1 || (prio == PRIO_REQ0));
            grant1 = elig1 && (!elig0 || (prio == PRIO_REQ1));
        end
        if (grant0) begin
            prio_next = PRIO_REQ1;
        end else if (grant1) begin
            prio_next = PRIO_REQ0;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        alu_din_0 = req0_din_0;
        alu_din_1 = req0_din_1;
        alu_ctrl  = req0_ctrl;
        if (grant1) begin
            alu_din_0 = req1_din_0;
            alu_din_1 = req1_din_1;
            alu_ctrl  = req1_ctrl;
        end
    end

    ALU #(
        .REG_DATA_WIDTH(REG_DATA_WIDTH)
    ) u_alu (
        .clk   (clk),
        .nreset(nreset),
        .din_0 (alu_din_0),
        .din_1 (alu_din_1),
        .ctrl  (alu_ctrl),
        .result(alu_result)
    );

    alu_arb_slot #(
        .WIDTH(REG_DATA_WIDTH)
    ) u_slot0 (
        .clk   (clk),
        .nreset(nreset),
        .push  (grant0),
        .pop   (pop0),
        .din   (alu_result),
        .valid (rsp0_valid),
        .result(rsp0_result)
    );

    alu_arb_slot #(
        .WIDTH(REG_DATA_WIDTH)
    ) u_slot1 (
        .clk   (clk),
        .nreset(nreset),
        .push  (grant1),
        .pop   (pop1),
        .din   (alu_result),
        .valid (rsp1_valid),
        .result(rsp1_result)
    );

`ifdef ALU_ARB_STATS_EN
    logic [31:0] grant_cnt0, grant_cnt1;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (grant0 && (grant_cnt0 != 32'hFFFF_FFFF)) grant_cnt0 <= grant_cnt0 + 32'd1;
            if (grant1 && (grant_cnt1 != 32'hFFFF_FFFF)) grant_cnt1 <= grant_cnt1 + 32'd1;
        end
    end

    assign stat_grant0 = grant_cnt0;
    assign stat_grant1 = grant_cnt1;
`else
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter against a transaction-level reference model.
// Stats counter checks are compiled in only when ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        nreset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_din_0, req0_din_1, req1_din_0, req1_din_1;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
`ifdef ALU_ARB_STATS_EN
    logic [31:0] stat_grant0, stat_grant1;
`endif

    int total = 0;
    int bad   = 0;

    logic        m_valid [2];
    logic [31:0] m_result[2];
    int          m_turn;
    int          m_grants[2];

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .nreset     (nreset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_din_0 (req0_din_0),
        .req0_din_1 (req0_din_1),
        .req0_ctrl  (req0_ctrl),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_din_0 (req1_din_0),
        .req1_din_1 (req1_din_1),
        .req1_ctrl  (req1_ctrl),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_result(rsp0_result),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
`ifdef ALU_ARB_STATS_EN
        .rsp1_result(rsp1_result),
        .stat_grant0(stat_grant0),
        .stat_grant1(stat_grant1)
`else
        .rsp1_result(rsp1_result)
`endif
    );

    // Reference ALU written from the op definitions; SRA built from a logical shift of the complement.
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a << sh;
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a >> sh;
            4'b1101: return a[31] ? ~((~a) >> sh) : (a >> sh);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_valid[0] = 1'b0;  m_valid[1] = 1'b0;
        m_result[0] = '0;   m_result[1] = '0;
        m_turn = 0;
        m_grants[0] = 0;    m_grants[1] = 0;
    endtask

    task automatic set_req(input int n, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (n == 0) begin
            req0_valid = v; req0_ctrl = op; req0_din_0 = a; req0_din_1 = b;
        end else begin
            req1_valid = v; req1_ctrl = op; req1_din_0 = a; req1_din_1 = b;
        end
    endtask

    // One clock: check ready mid-cycle, advance the model on the edge, check slots just after it.
    task automatic apply_stimulus();
        logic want [2];
        logic take [2];
        logic win  [2];
        logic [31:0] res [2];
        logic rdy [2];
        @(negedge clk);
        want[0] = req0_valid;  want[1] = req1_valid;
        take[0] = rsp0_ready;  take[1] = rsp1_ready;
        res[0]  = alu_ref(req0_ctrl, req0_din_0, req0_din_1);
        res[1]  = alu_ref(req1_ctrl, req1_din_0, req1_din_1);
        for (int n = 0; n < 2; n++) rdy[n] = want[n] && (!m_valid[n] || take[n]);
        if (rdy[0] && rdy[1]) begin
            win[m_turn] = 1'b1; win[1 - m_turn] = 1'b0;
        end else begin
            win[0] = rdy[0]; win[1] = rdy[1];
        end
        check_output("req0_ready", {31'd0, req0_ready}, {31'd0, win[0]});
        check_output("req1_ready", {31'd0, req1_ready}, {31'd0, win[1]});
        @(posedge clk);
        for (int n = 0; n < 2; n++) begin
            if (win[n]) begin
                m_valid[n]  = 1'b1;
                m_result[n] = res[n];
                m_turn      = 1 - n;
                m_grants[n]++;
            end else if (m_valid[n] && take[n]) begin
                m_valid[n] = 1'b0;
            end
        end
        #1;
        check_output("rsp0_valid",  {31'd0, rsp0_valid}, {31'd0, m_valid[0]});
        check_output("rsp1_valid",  {31'd0, rsp1_valid}, {31'd0, m_valid[1]});
        check_output("rsp0_result", rsp0_result, m_result[0]);
        check_output("rsp1_result", rsp1_result, m_result[1]);
    endtask

    initial begin
        logic [3:0] op_list [10];
        op_list = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                    4'b0101, 4'b1101, 4'b0110, 4'b0111, 4'b1010};

        // Reset with both requesters asserting valid: nothing may be accepted.
        nreset = 1'b0;
        model_reset();
        set_req(0, 1'b1, 4'b0000, 32'h1, 32'h2);
        set_req(1, 1'b1, 4'b0000, 32'h3, 32'h4);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #2;
        check_output("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
        check_output("reset_req1_ready", {31'd0, req1_ready}, 32'd0);
        check_output("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        check_output("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        check_output("reset_rsp0_result", rsp0_result, 32'd0);
        check_output("reset_rsp1_result", rsp1_result, 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;

        // Wrap-around add on requester 0 alone.
        set_req(0, 1'b1, 4'b0000, 32'hFFFF_FFFF, 32'h1);
        set_req(1, 1'b0, 4'b0000, 32'h0, 32'h0);
        apply_stimulus();
        check_output("add_wrap", rsp0_result, 32'h0000_0000);

        // Requester 1 alone hands the pointer back to 0, then both contend.
        set_req(0, 1'b0, 4'b0000, 32'd5, 32'd3);
        set_req(1, 1'b1, 4'b0001, 32'd1, 32'd31);
        apply_stimulus();
        set_req(0, 1'b1, 4'b0000, 32'd5, 32'd3);
        for (int i = 0; i < 4; i++) apply_stimulus();
        check_output("contend_rsp0", rsp0_result, 32'd8);
        check_output("contend_rsp1", rsp1_result, 32'h8000_0000);

        // Backpressure on slot 0 while requester 1 keeps flowing.
        set_req(1, 1'b0, 4'b0000, 32'd0, 32'd0);
        set_req(0, 1'b1, 4'b0000, 32'd7, 32'd1);
        rsp0_ready = 1'b0;
        apply_stimulus();
        set_req(0, 1'b1, 4'b0100, 32'hDEAD_BEEF, 32'h1234_5678);
        set_req(1, 1'b1, 4'b0110, 32'hF0F0_0000, 32'h0000_0F0F);
        for (int i = 0; i < 3; i++) apply_stimulus();
        check_output("stall_hold", rsp0_result, 32'd8);
        rsp0_ready = 1'b1;
        apply_stimulus();

        // Drain and refill slot 0 in the same cycle.
        set_req(1, 1'b0, 4'b0000, 32'd0, 32'd0);
        set_req(0, 1'b1, 4'b1101, 32'h8000_0000, 32'd4);
        apply_stimulus();
        check_output("sra_refill", rsp0_result, 32'hF800_0000);

        // Leave slot 1 full with the pointer on requester 1, then reset mid-flight.
        rsp1_ready = 1'b0;
        set_req(0, 1'b0, 4'b0000, 32'd0, 32'd0);
        set_req(1, 1'b1, 4'b0111, 32'hFF00_FF00, 32'h0FF0_0FF0);
        apply_stimulus();
        set_req(1, 1'b0, 4'b0000, 32'd0, 32'd0);
        set_req(0, 1'b1, 4'b0011, 32'd1, 32'hFFFF_FFFF);
        apply_stimulus();
        check_output("pre_reset_rsp1", {31'd0, rsp1_valid}, 32'd1);
        nreset = 1'b0;
        #1;
        model_reset();
        check_output("async_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        check_output("async_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        #2;
        nreset = 1'b1;
        rsp1_ready = 1'b1;
        set_req(0, 1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd0);
        set_req(1, 1'b1, 4'b0101, 32'h8000_0000, 32'd31);
        apply_stimulus();
        check_output("post_reset_first", {31'd0, rsp0_valid}, 32'd1);

        // Randomized traffic with random backpressure, including an unlisted op encoding.
        for (int i = 0; i < 300; i++) begin
            set_req(0, 1'($urandom_range(0, 3) != 0), op_list[$urandom_range(0, 9)], $urandom, $urandom);
            set_req(1, 1'($urandom_range(0, 3) != 0), op_list[$urandom_range(0, 9)], $urandom, $urandom);
            rsp0_ready = 1'($urandom_range(0, 2) != 0);
            rsp1_ready = 1'($urandom_range(0, 2) != 0);
            apply_stimulus();
        end

`ifdef ALU_ARB_STATS_EN
        check_output("stat_grant0", stat_grant0, 32'(m_grants[0]));
        check_output("stat_grant1", stat_grant1, 32'(m_grants[1]));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

- Shares one ALU instance between two requesters:
  - requester 0: execute stage;
  - requester 1: address-generation/branch-target unit.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. Each requester has a one-entry registered response slot, giving single-cycle latency and full throughput under no backpressure.
- Sits between the issue logic and the existing `ALU` module, which it instantiates internally.

## Interface
Parameters:
- `REG_DATA_WIDTH`, default 32: operand/result width.
- `CTRL_WIDTH`, default 4: ALU op width (from package).

Ports:
- `clk` in 1: clock, all state on rising edge.
- `nreset` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has an op.
- `req0_ready` out 1: requester 0 op accepted this cycle.
- `req0_din_0` in `REG_DATA_WIDTH`: operand 0.
- `req0_din_1` in `REG_DATA_WIDTH`: operand 1.
- `req0_ctrl` in `CTRL_WIDTH`: ALU op.
- `req1_valid`, `req1_ready`, `req1_din_0`, `req1_din_1`, `req1_ctrl`: same as requester 0, for requester 1.
- `rsp0_valid` out 1: result slot 0 full.
- `rsp0_ready` in 1: consumer 0 takes result.
- `rsp0_result` out `REG_DATA_WIDTH`: result for requester 0.
- `rsp1_valid`, `rsp1_ready`, `rsp1_result`: same as response 0, for requester 1.

## Operation
- **Eligibility:** requester N is eligible when `reqN_valid` && (`!rspN_valid` || `rspN_ready`).
  - A slot drained in a cycle may be refilled in the same cycle.
- **Priority pointer `prio`** (1 bit, reset 0):
  - If both requesters are eligible, the one selected by `prio` is granted.
  - If only one is eligible, it is granted.
  - If neither is eligible, there is no grant.
- **Pointer update:** after any grant to N, `prio` <= the other requester. With no grant, `prio` holds.
- **Ready:** `reqN_ready` = grant to N, combinational.
  - Depends on `reqN_valid`, the other requester's valid, `rspN_valid`/`rspN_ready` and `prio`.
  - Never depends on operand values.
- **ALU drive:** ALU inputs `din_0`/`din_1`/`ctrl` are muxed from the granted requester. With no grant, requester 0's fields are driven (don't-care).
- **Capture:** on the granting edge, the ALU `result` is written into slot N and `rspN_valid` <= 1.
- **Slot clear:** if slot N is popped (`rspN_valid` && `rspN_ready`) without refill, `rspN_valid` <= 0.
- **Slot hold:** while `rspN_valid` && !`rspN_ready`, `rspN_result` is held stable.
- **Pass-through:** ctrl encodings outside the package list are passed to the ALU unchanged; the result is whatever the ALU returns.
- **Reset values:**
  - `rsp0_valid` = `rsp1_valid` = 0.
  - `rsp0_result` = `rsp1_result` = 0.
  - `prio` = 0.
  - `req*_ready` = 0 whenever `nreset` = 0.
- **Reset mid-operation:** pending results are discarded without a response.

## Timing
- Latency: the op accepted at edge k appears as `rspN_valid`=1 with its result immediately after edge k.
- Throughput:
  - one op per cycle total;
  - one op per cycle per requester if the other is idle.
- Both requesters continuously eligible: grants alternate 0,1,0,1,… starting from `prio`.
- Critical path: `reqN_*` → mux → ALU → slot register. No registered operand stage.
- Reset assert is asynchronous (outputs clear immediately). Deassert is synchronized externally.

## Configuration
- **`ALU_ARB_STATS_EN` defined:** adds outputs `stat_grant0` and `stat_grant1` (out, 32 bits each).
  - Each increments on every grant to that requester.
  - Saturates at 0xFFFFFFFF.
  - Resets to 0.
- **Undefined:** the ports and counters do not exist; all other behaviour is identical.

## Structure
- Package `alu_pkg`:
  - `CTRL_WIDTH` = 4.
  - Op constants: ADD 4'b0000, SLL 4'b0001, SLT 4'b0010, SLTU 4'b0011, XOR 4'b0100, SRL 4'b0101, SRA 4'b1101, OR 4'b0110, AND 4'b0111.
  - These are shared with the decoder and the ALU.
- Sub-module `alu_arb_slot`: one-entry response buffer (valid, result, push, pop, stall hold), instantiated twice.
- Existing `ALU` is instantiated once, with `clk`/`nreset` passed through.

## Test plan
1. **Reset:** `nreset`=0 → both `rsp*_valid`=0, `rsp*_result`=0, `req*_ready`=0. Release, then req0 ADD 0xFFFFFFFF+0x1 → `req0_ready`=1; next cycle `rsp0_valid`=1, `rsp0_result`=0x00000000.
2. **Contention:** `rsp*_ready`=1; req0 ADD 5+3 and req1 SLL 1<<31 held valid for 4 cycles → grants 0,1,0,1. `rsp0_result`=8 and `rsp1_result`=0x80000000, each valid every other cycle.
3. **Backpressure:** slot 0 full, `rsp0_ready`=0, req0 and req1 valid → `req0_ready`=0, req1 granted every cycle, `rsp0_result` stable. Raise `rsp0_ready` → req0 granted that same cycle.
4. **Drain and refill:** `rsp0_valid`=1, `rsp0_ready`=1, req0 SRA 0x80000000>>>4 → accepted. Next cycle `rsp0_result`=0xF8000000, no bubble.
5. **Reset mid-operation:** `rsp1_valid`=1 and `prio`=1; pulse `nreset` low → `rsp1_valid`=0 immediately. After release, with both valid → req0 granted first.
6. **`ALU_ARB_STATS_EN`:** 3 grants to req0 and 2 to req1 → `stat_grant0`=3, `stat_grant1`=2. Preload near saturation → counter holds at 0xFFFFFFFF.
